icache_miss_ctlr: RTL and testbench

Next-generation L1 instruction-cache controller. It keeps the existing set decode, hit detection and branch-aware replacement permit. It adds a full miss-handling FSM: a one-cycle branch-resolution delay, a memory request handshake, a multi-beat line refill, and a whole-cache invalidate sweep. It sits between the fetch stage, the l1_icache data/tag arrays and the next-level memory port.

---
 rtl/icache_ctlr_pkg.sv | 20 ++
 rtl/wrap_counter.sv | 41 ++++
 rtl/icache_miss_ctlr.sv | 210 +++++++++++++++++++++
 tb/tb_icache_miss_ctlr.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_ctlr_pkg.sv
// -----------------------------------------------------------------------------
// icache_ctlr_pkg
//   Shared types and constants for the L1 instruction-cache miss controller.
//   - state_t    : miss-handling FSM states
//   - NON_BRANCH : branch-op encoding of an instruction that is not a branch
// -----------------------------------------------------------------------------
package icache_ctlr_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DELAY  = 3'd1,
        REQ    = 3'd2,
        REFILL = 3'd3,
        FLUSH  = 3'd4
    } state_t;

    // Branch-op encoding shared with the pipeline control decode.
    localparam logic [1:0] NON_BRANCH = 2'b00;

endpackage

// File: rtl/wrap_counter.sv
// -----------------------------------------------------------------------------
// wrap_counter
//   Free-running up-counter over 0..MAX-1 that wraps to 0 by natural overflow.
//   MAX must be a power of two (at least 2), so no modulo compare is needed.
//   Ports:
//     clk    in   clock
//     rst    in   asynchronous active-high reset (count -> 0)
//     enable in   advance by one this cycle
//     clear  in   force count to 0 next cycle (wins over enable)
//     count  out  current value, $clog2(MAX) bits
//     last   out  count == MAX-1
// -----------------------------------------------------------------------------
module wrap_counter #(
    parameter int MAX = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   clear,
    output logic [$clog2(MAX)-1:0] count,
    output logic                   last
);

    localparam int W = $clog2(MAX);

    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + W'(1);
        end
    end

    // All-ones is MAX-1 because MAX is a power of two.
    assign last = &count;

endmodule

// File: rtl/icache_miss_ctlr.sv
// -----------------------------------------------------------------------------
// icache_miss_ctlr
//   L1 instruction-cache controller: set decode, hit detection, branch-aware
//   replacement permit, and a miss FSM (branch-resolution delay, memory
//   request handshake, multi-beat refill, whole-cache invalidate sweep).
//   Ports:
//     clk_i, reset_i     clock, asynchronous active-high reset
//     set_i              set index of the current fetch PC
//     miss_array_i       per-set miss flags from the arrays
//     pc_src_reg_i       registered PC source; bit 1 = redirect in flight
//     branch_op_e_i      branch-op of the instruction in Execute
//     flush_i            request a whole-cache invalidate
//     mem_rvalid_i       refill beat valid
//     mem_req_ready_i    memory accepts the line request
//     active_array_o     one-hot decode of set_i
//     instr_hit_f_o      fetch hit (0 while sweeping)
//     ic_repl_permit_o   replacement permitted this cycle
//     stall_f_o          stall fetch
//     mem_req_valid_o    line-fill request valid
//     req_set_o          set being refilled (latched at request)
//     refill_we_o        write current beat into the line
//     refill_beat_o      word index of the current beat
//     refill_done_o      pulse on the last beat
//     inv_valid_o        invalidate set inv_set_o
//     inv_set_o          set being invalidated
// -----------------------------------------------------------------------------
module icache_miss_ctlr
    import icache_ctlr_pkg::*;
#(
    parameter int S           = 64,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [$clog2(S)-1:0]           set_i,
    input  logic [S-1:0]                   miss_array_i,
    input  logic [1:0]                     pc_src_reg_i,
    input  logic [1:0]                     branch_op_e_i,
    input  logic                           flush_i,
    input  logic                           mem_rvalid_i,
    input  logic                           mem_req_ready_i,
    output logic [S-1:0]                   active_array_o,
    output logic                           instr_hit_f_o,
    output logic                           ic_repl_permit_o,
    output logic                           stall_f_o,
    output logic                           mem_req_valid_o,
    output logic [$clog2(S)-1:0]           req_set_o,
    output logic                           refill_we_o,
    output logic [$clog2(BLOCK_WORDS)-1:0] refill_beat_o,
    output logic                           refill_done_o,
    output logic                           inv_valid_o,
    output logic [$clog2(S)-1:0]           inv_set_o
);

    localparam int SET_W  = $clog2(S);
    localparam int BEAT_W = $clog2(BLOCK_WORDS);

    state_t             state;
    logic               flush_pending;
    logic [SET_W-1:0]   req_set;
    logic               mem_req_valid;
    logic               inv_valid;

    logic               redirect;
    logic               hit;
    logic               permit;

    logic               beat_en;
    logic               beat_clr;
    logic               beat_last;
    logic [BEAT_W-1:0]  beat;
    logic               sweep_en;
    logic               sweep_last;
    logic [SET_W-1:0]   sweep;

    // pc_src_reg_i[0] only selects among non-redirect sources; not needed here.
    logic               unused_pc_src;
    assign unused_pc_src = pc_src_reg_i[0];

    assign redirect = pc_src_reg_i[1];

    // ------------------------------------------------------------------
    // Lookup-side combinational outputs
    // ------------------------------------------------------------------
    assign active_array_o = S'(1) << set_i;

    // Lines are being invalidated during the sweep, so nothing may hit.
    assign hit = ~miss_array_i[set_i] & (state != FLUSH);

    // DELAY means the branch has had its extra cycle to resolve.
    assign permit = ((branch_op_e_i == NON_BRANCH) | hit | (state == DELAY))
                    & ~redirect;

    assign instr_hit_f_o    = hit;
    assign ic_repl_permit_o = permit;
    assign stall_f_o        = (state != IDLE) | (~hit & ~redirect);

    // ------------------------------------------------------------------
    // Counters: refill beats and invalidate sweep
    // ------------------------------------------------------------------
    assign beat_en  = (state == REFILL) & mem_rvalid_i;
    assign beat_clr = (state == REQ) & mem_req_ready_i;
    assign sweep_en = (state == FLUSH);

    wrap_counter #(
        .MAX    (BLOCK_WORDS)
    ) u_beat_cnt (
        .clk    (clk_i),
        .rst    (reset_i),
        .enable (beat_en),
        .clear  (beat_clr),
        .count  (beat),
        .last   (beat_last)
    );

    // The sweep always ends on S-1 and wraps to 0, so it never needs a clear.
    wrap_counter #(
        .MAX    (S)
    ) u_sweep_cnt (
        .clk    (clk_i),
        .rst    (reset_i),
        .enable (sweep_en),
        .clear  (1'b0),
        .count  (sweep),
        .last   (sweep_last)
    );

    // Beat writes follow rvalid in the same cycle, so they are decoded
    // from the state register rather than registered.
    assign refill_we_o     = beat_en;
    assign refill_beat_o   = beat;
    assign refill_done_o   = beat_en & beat_last;

    assign mem_req_valid_o = mem_req_valid;
    assign req_set_o       = req_set;
    assign inv_valid_o     = inv_valid;
    assign inv_set_o       = sweep;

    // ------------------------------------------------------------------
    // Miss-handling FSM with registered request/invalidate strobes
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state         <= IDLE;
            flush_pending <= 1'b0;
            req_set       <= '0;
            mem_req_valid <= 1'b0;
            inv_valid     <= 1'b0;
        end else begin
            // A flush arriving mid-miss waits for the line to complete.
            if (flush_i && (state inside {DELAY, REQ, REFILL})) begin
                flush_pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (flush_i || flush_pending) begin
                        state         <= FLUSH;
                        flush_pending <= 1'b0;
                        inv_valid     <= 1'b1;
                    end else if (!hit && permit) begin
                        state         <= REQ;
                        req_set       <= set_i;
                        mem_req_valid <= 1'b1;
                    end else if (!hit && !redirect) begin
                        state         <= DELAY;
                    end
                end

                DELAY: begin
                    if (redirect || hit) begin
                        state         <= IDLE;
                    end else begin
                        state         <= REQ;
                        req_set       <= set_i;
                        mem_req_valid <= 1'b1;
                    end
                end

                // A redirect no longer aborts once the request is issued.
                REQ: begin
                    if (mem_req_ready_i) begin
                        state         <= REFILL;
                        mem_req_valid <= 1'b0;
                    end
                end

                REFILL: begin
                    if (beat_en && beat_last) begin
                        state         <= IDLE;
                    end
                end

                FLUSH: begin
                    if (sweep_last) begin
                        state         <= IDLE;
                        inv_valid     <= 1'b0;
                    end
                end

                default: begin
                    state         <= IDLE;
                    mem_req_valid <= 1'b0;
                    inv_valid     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_miss_ctlr.sv
// -----------------------------------------------------------------------------
// tb_icache_miss_ctlr
//   Directed stimulus pushes expected request/beat/invalidate events into a
//   scoreboard queue; a negedge monitor pops and compares whenever the DUT
//   presents one. Cycle-level expectations are checked inline.
// -----------------------------------------------------------------------------
module tb_icache_miss_ctlr;
    import icache_ctlr_pkg::*;

    localparam int S      = 64;
    localparam int BW     = 4;
    localparam int SET_W  = 6;
    localparam int BEAT_W = 2;

    logic              clk;
    logic              reset_i;
    logic [SET_W-1:0]  set_i;
    logic [S-1:0]      miss_array_i;
    logic [1:0]        pc_src_reg_i;
    logic [1:0]        branch_op_e_i;
    logic              flush_i;
    logic              mem_rvalid_i;
    logic              mem_req_ready_i;
    logic [S-1:0]      active_array_o;
    logic              instr_hit_f_o;
    logic              ic_repl_permit_o;
    logic              stall_f_o;
    logic              mem_req_valid_o;
    logic [SET_W-1:0]  req_set_o;
    logic              refill_we_o;
    logic [BEAT_W-1:0] refill_beat_o;
    logic              refill_done_o;
    logic              inv_valid_o;
    logic [SET_W-1:0]  inv_set_o;

    icache_miss_ctlr #(
        .S                (S),
        .BLOCK_WORDS      (BW)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .set_i            (set_i),
        .miss_array_i     (miss_array_i),
        .pc_src_reg_i     (pc_src_reg_i),
        .branch_op_e_i    (branch_op_e_i),
        .flush_i          (flush_i),
        .mem_rvalid_i     (mem_rvalid_i),
        .mem_req_ready_i  (mem_req_ready_i),
        .active_array_o   (active_array_o),
        .instr_hit_f_o    (instr_hit_f_o),
        .ic_repl_permit_o (ic_repl_permit_o),
        .stall_f_o        (stall_f_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .req_set_o        (req_set_o),
        .refill_we_o      (refill_we_o),
        .refill_beat_o    (refill_beat_o),
        .refill_done_o    (refill_done_o),
        .inv_valid_o      (inv_valid_o),
        .inv_set_o        (inv_set_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {EV_REQ, EV_BEAT, EV_INV} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       value;
        bit       done;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input ev_kind_t k, input int v, input bit d);
        ev_t e;
        e.kind  = k;
        e.value = v;
        e.done  = d;
        exp_q.push_back(e);
    endtask

    task automatic push_line(input int set);
        push(EV_REQ, set, 1'b0);
        for (int b = 0; b < BW; b++) push(EV_BEAT, b, (b == BW - 1));
    endtask

    task automatic push_sweep();
        for (int k = 0; k < S; k++) push(EV_INV, k, 1'b0);
    endtask

    task automatic observe(input ev_kind_t k, input int v, input bit d);
        ev_t e;
        if (exp_q.size() == 0) begin
            check($sformatf("unexpected_event_kind%0d_val%0d", k, v), 0, 1);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", k, e.kind);
            check("event_value", v, e.value);
            if (k == EV_BEAT) check("refill_done", d, e.done);
        end
    endtask

    // Scoreboard monitor, sampling on the inactive edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_i) begin
                if (refill_done_o) check("done_needs_we", refill_we_o, 1);
                if (mem_req_valid_o && mem_req_ready_i)
                    observe(EV_REQ, int'(req_set_o), 1'b0);
                if (refill_we_o)
                    observe(EV_BEAT, int'(refill_beat_o), refill_done_o);
                if (inv_valid_o)
                    observe(EV_INV, int'(inv_set_o), 1'b0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic miss_at(input int set);
        set_i        = SET_W'(set);
        miss_array_i = '0;
        miss_array_i[set] = 1'b1;
    endtask

    initial begin
        reset_i         = 1'b1;
        set_i           = '0;
        miss_array_i    = '0;
        pc_src_reg_i    = 2'b00;
        branch_op_e_i   = NON_BRANCH;
        flush_i         = 1'b0;
        mem_rvalid_i    = 1'b0;
        mem_req_ready_i = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_valid", mem_req_valid_o, 0);
        check("rst_refill_we", refill_we_o, 0);
        check("rst_refill_done", refill_done_o, 0);
        check("rst_inv_valid", inv_valid_o, 0);
        check("rst_beat", refill_beat_o, 0);
        check("rst_inv_set", inv_set_o, 0);
        check("rst_req_set", req_set_o, 0);
        check("rst_stall", stall_f_o, 0);
        reset_i = 1'b0;

        // Set decode
        set_i = 6'd5;  #1; check("active_array_5", active_array_o, 64'h20);
        set_i = 6'd63; #1; check("active_array_63", active_array_o, 64'h8000_0000_0000_0000);
        set_i = 6'd0;  #1; check("active_array_0", active_array_o, 64'h1);
        step();

        // Test 1: reset asserted mid-refill at beat 2
        push(EV_REQ, 9, 1'b0);
        push(EV_BEAT, 0, 1'b0);
        push(EV_BEAT, 1, 1'b0);
        miss_at(9);
        step();                                   // -> REQ
        check("t1_req_valid", mem_req_valid_o, 1);
        miss_array_i    = '0;
        mem_req_ready_i = 1'b1;
        step();                                   // -> REFILL
        mem_req_ready_i = 1'b0;
        mem_rvalid_i    = 1'b1;
        step();                                   // beat 0 written
        step();                                   // beat 1 written
        mem_rvalid_i = 1'b0;
        #1;
        check("t1_beat_before_rst", refill_beat_o, 2);
        reset_i = 1'b1;
        #1;
        check("t1_rst_beat", refill_beat_o, 0);
        check("t1_rst_we", refill_we_o, 0);
        check("t1_rst_req_valid", mem_req_valid_o, 0);
        step();
        reset_i      = 1'b0;
        mem_rvalid_i = 1'b1;                      // must be ignored in IDLE
        #1;
        check("t1_idle_we", refill_we_o, 0);
        check("t1_idle_req_valid", mem_req_valid_o, 0);
        check("t1_idle_beat", refill_beat_o, 0);
        check("t1_idle_stall", stall_f_o, 0);
        step();
        mem_rvalid_i = 1'b0;

        // Test 2: non-branch miss on set 5, slow ready, gapped beats
        push_line(5);
        miss_at(5);
        #1;
        check("t2_permit", ic_repl_permit_o, 1);
        check("t2_stall_miss", stall_f_o, 1);
        step();                                   // -> REQ
        miss_array_i = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t2_req_valid_wait", mem_req_valid_o, 1);
            check("t2_req_set", req_set_o, 5);
            step();
        end
        mem_req_ready_i = 1'b1;
        step();                                   // -> REFILL
        mem_req_ready_i = 1'b0;
        #1;
        check("t2_req_valid_dropped", mem_req_valid_o, 0);
        begin
            bit pat[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
            for (int i = 0; i < 5; i++) begin
                mem_rvalid_i = pat[i];
                #1;
                if (!pat[i]) begin
                    check("t2_gap_we", refill_we_o, 0);
                    check("t2_gap_beat_hold", refill_beat_o, 1);
                end
                step();
            end
        end
        #1;                                       // rvalid still 1, now IDLE
        check("t2_idle_we", refill_we_o, 0);
        check("t2_idle_stall", stall_f_o, 0);
        check("t2_idle_req_valid", mem_req_valid_o, 0);
        step();
        mem_rvalid_i = 1'b0;

        // Test 3: branch-pending miss, redirect while in DELAY
        miss_at(3);
        branch_op_e_i = 2'b01;
        #1;
        check("t3_permit_idle", ic_repl_permit_o, 0);
        check("t3_stall_idle", stall_f_o, 1);
        step();                                   // -> DELAY
        pc_src_reg_i = 2'b10;
        #1;
        check("t3_delay_stall", stall_f_o, 1);
        check("t3_delay_req_valid", mem_req_valid_o, 0);
        check("t3_delay_permit", ic_repl_permit_o, 0);
        step();                                   // -> IDLE
        #1;
        check("t3_back_idle_stall", stall_f_o, 0);
        check("t3_back_idle_req_valid", mem_req_valid_o, 0);
        miss_array_i  = '0;
        pc_src_reg_i  = 2'b00;
        branch_op_e_i = NON_BRANCH;
        step();
        #1;
        check("t3_no_req", mem_req_valid_o, 0);

        // Test 4: branch-pending miss, DELAY for exactly one cycle then REQ
        push_line(7);
        miss_at(7);
        branch_op_e_i = 2'b10;
        step();                                   // -> DELAY
        #1;
        check("t4_delay_permit", ic_repl_permit_o, 1);
        check("t4_delay_req_valid", mem_req_valid_o, 0);
        check("t4_delay_stall", stall_f_o, 1);
        step();                                   // -> REQ
        #1;
        check("t4_req_valid", mem_req_valid_o, 1);
        check("t4_req_set", req_set_o, 7);
        miss_array_i    = '0;
        mem_req_ready_i = 1'b1;
        step();                                   // -> REFILL
        mem_req_ready_i = 1'b0;
        mem_rvalid_i    = 1'b1;
        repeat (BW) step();
        mem_rvalid_i  = 1'b0;
        branch_op_e_i = NON_BRANCH;
        #1;
        check("t4_idle_stall", stall_f_o, 0);

        // Test 5: flush in IDLE sweeps every set once; re-flush is merged
        set_i        = 6'd0;
        miss_array_i = '0;
        push_sweep();
        flush_i = 1'b1;
        step();                                   // -> FLUSH
        flush_i = 1'b0;
        for (int k = 0; k < S; k++) begin
            #1;
            check("t5_hit_forced_low", instr_hit_f_o, 0);
            check("t5_stall", stall_f_o, 1);
            flush_i = (k == 10);
            step();
        end
        flush_i = 1'b0;
        #1;
        check("t5_inv_done", inv_valid_o, 0);
        check("t5_hit_after", instr_hit_f_o, 1);
        check("t5_sweep_wrapped", inv_set_o, 0);
        repeat (3) step();
        check("t5_no_second_sweep", inv_valid_o, 0);

        // Test 6: flush during refill beat 1 waits for the line, then sweeps
        push_line(12);
        push_sweep();
        miss_at(12);
        step();                                   // -> REQ
        miss_array_i    = '0;
        mem_req_ready_i = 1'b1;
        step();                                   // -> REFILL
        mem_req_ready_i = 1'b0;
        mem_rvalid_i    = 1'b1;
        step();                                   // beat 0
        flush_i = 1'b1;
        #1;
        check("t6_no_abort_we", refill_we_o, 1);
        step();                                   // beat 1
        flush_i = 1'b0;
        step();                                   // beat 2
        step();                                   // beat 3
        mem_rvalid_i = 1'b0;
        #1;
        check("t6_idle_inv", inv_valid_o, 0);
        check("t6_idle_we", refill_we_o, 0);
        step();                                   // -> FLUSH
        #1;
        check("t6_flush_started", inv_valid_o, 1);
        check("t6_flush_first_set", inv_set_o, 0);
        repeat (S) step();
        check("t6_flush_done", inv_valid_o, 0);

        repeat (3) step();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
